// File: rtl/write_ptr_full_ctrl_pkg.sv
// Shared defaults for the async FIFO write-side pointer logic.
// Holds the default address width, the depth helper and the almost-full level.
package write_ptr_full_ctrl_pkg;

  localparam int DEF_ADDR_SIZE = 4;

  function automatic int fifo_depth(input int addr_size);
    return 2 ** addr_size;
  endfunction

  localparam int DEF_AFULL_THRESH = fifo_depth(DEF_ADDR_SIZE) - 2;

endpackage

// File: rtl/write_ptr_full_ctrl_gray2bin.sv
// Parametrised Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/write_ptr_full_ctrl.sv
// Write-side pointer, full/almost-full and occupancy tracking for an async FIFO.
// Optional sticky overflow flag is built when WRITE_FULL_OVF_EN is defined.
module write_ptr_full_ctrl
  import write_ptr_full_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
  parameter int AFULL_THRESH = fifo_depth(ADDR_SIZE) - 2
) (
  input  logic                 write_clk,
  input  logic                 write_reset,
  input  logic                 write_inc,
  input  logic [ADDR_SIZE:0]   read_ptr_sync,
  input  logic                 ovf_clear,
  output logic [ADDR_SIZE-1:0] write_addr,
  output logic [ADDR_SIZE:0]   write_ptr,
  output logic                 write_en,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   write_level,
  output logic                 overflow
);

  localparam logic [ADDR_SIZE:0] THRESH = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] bin;
  logic [ADDR_SIZE:0] gray;
  logic [ADDR_SIZE:0] next_bin;
  logic [ADDR_SIZE:0] next_gray;
  logic [ADDR_SIZE:0] next_level;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] full_ptr;
  logic               next_full;
  logic               next_afull;

  gray2bin #(
    .WIDTH(ADDR_SIZE + 1)
  ) u_rd_g2b (
    .gray(read_ptr_sync),
    .bin (rbin)
  );

  assign write_en   = write_inc & ~full;
  assign write_addr = bin[ADDR_SIZE-1:0];
  assign write_ptr  = gray;

  // Full pattern: read pointer with its two MSBs flipped, one lap behind.
  assign full_ptr = {~read_ptr_sync[ADDR_SIZE:ADDR_SIZE-1],
                     read_ptr_sync[ADDR_SIZE-2:0]};

  // Look-ahead pointer, level and flags so full rises with the filling write.
  always_comb begin
    next_bin   = bin + {{ADDR_SIZE{1'b0}}, write_en};
    next_gray  = (next_bin >> 1) ^ next_bin;
    next_level = next_bin - rbin;
    next_full  = (next_gray == full_ptr);
    next_afull = (next_level >= THRESH);
  end

  // Pointer and status registers.
  always_ff @(posedge write_clk or negedge write_reset) begin
    if (!write_reset) begin
      bin         <= '0;
      gray        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      write_level <= '0;
    end else begin
      bin         <= next_bin;
      gray        <= next_gray;
      full        <= next_full;
      almost_full <= next_afull;
      write_level <= next_level;
    end
  end

`ifdef WRITE_FULL_OVF_EN
  // Sticky overflow: a set in the same cycle wins over a clear.
  always_ff @(posedge write_clk or negedge write_reset) begin
    if (!write_reset) begin
      overflow <= 1'b0;
    end else if (write_inc && full) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ovf_clear;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_write_ptr_full_ctrl.sv
// Directed self-checking bench for write_ptr_full_ctrl.
// Uses ADDR_SIZE=4 and the default almost-full level of 14.
module tb_write_ptr_full_ctrl;

  logic       write_clk;
  logic       write_reset;
  logic       write_inc;
  logic [4:0] read_ptr_sync;
  logic       ovf_clear;
  logic [3:0] write_addr;
  logic [4:0] write_ptr;
  logic       write_en;
  logic       full;
  logic       almost_full;
  logic [4:0] write_level;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef WRITE_FULL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  write_ptr_full_ctrl #(
    .ADDR_SIZE   (4),
    .AFULL_THRESH(14)
  ) dut (
    .write_clk    (write_clk),
    .write_reset  (write_reset),
    .write_inc    (write_inc),
    .read_ptr_sync(read_ptr_sync),
    .ovf_clear    (ovf_clear),
    .write_addr   (write_addr),
    .write_ptr    (write_ptr),
    .write_en     (write_en),
    .full         (full),
    .almost_full  (almost_full),
    .write_level  (write_level),
    .overflow     (overflow)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge write_clk);
    #1;
  endtask

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [4:0] wb;
  logic [4:0] rb;

  initial begin
    write_reset   = 1'b0;
    write_inc     = 1'b0;
    read_ptr_sync = '0;
    ovf_clear     = 1'b0;
    #3;
    check("rst_addr", 32'(write_addr), 0);
    check("rst_ptr", 32'(write_ptr), 0);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_level", 32'(write_level), 0);
    check("rst_ovf", 32'(overflow), 0);
    step();
    step();
    #2 write_reset = 1'b1;
    step();

    // Fill 16 entries with the reader parked at 0.
    for (int i = 0; i < 16; i++) begin
      write_inc = 1'b1;
      #1;
      check("fill_addr", 32'(write_addr), 32'(i));
      check("fill_en", 32'(write_en), 1);
      step();
      check("fill_level", 32'(write_level), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
      check("fill_full", 32'(full), 32'((i + 1) == 16));
    end
    check("fill_ptr", 32'(write_ptr), 32'h18);

    // Writes while full are dropped.
    for (int i = 0; i < 3; i++) begin
      write_inc = 1'b1;
      #1;
      check("drop_en", 32'(write_en), 0);
      step();
      check("drop_addr", 32'(write_addr), 0);
      check("drop_ptr", 32'(write_ptr), 32'h18);
      check("drop_level", 32'(write_level), 16);
      check("drop_full", 32'(full), 1);
    end
    check("ovf_set", 32'(overflow), 32'(OVF_EXP));
    write_inc = 1'b0;
    ovf_clear = 1'b1;
    step();
    check("ovf_clr", 32'(overflow), 0);
    ovf_clear = 1'b0;

    // Reader advances by one.
    read_ptr_sync = 5'b00001;
    step();
    check("rd1_full", 32'(full), 0);
    check("rd1_level", 32'(write_level), 15);
    check("rd1_afull", 32'(almost_full), 1);

    // Simultaneous write and read at level 15.
    wb = 5'd17;
    rb = 5'd2;
    read_ptr_sync = to_gray(rb);
    write_inc = 1'b1;
    #1;
    check("sim_en", 32'(write_en), 1);
    step();
    check("sim_level", 32'(write_level), 15);
    check("sim_full", 32'(full), 0);

    // Streaming with a matching reader across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      wb = wb + 5'd1;
      rb = rb + 5'd1;
      read_ptr_sync = to_gray(rb);
      step();
      check("wrap_level", 32'(write_level), 15);
      check("wrap_full", 32'(full), 0);
      check("wrap_addr", 32'(write_addr), 32'(wb[3:0]));
      check("wrap_ptr", 32'(write_ptr), 32'(to_gray(wb)));
    end

    // Settle at level 9, then reset with no clock edge.
    write_inc = 1'b0;
    rb = wb - 5'd9;
    read_ptr_sync = to_gray(rb);
    step();
    check("lvl9", 32'(write_level), 9);
    #2 write_reset = 1'b0;
    #1;
    check("arst_addr", 32'(write_addr), 0);
    check("arst_ptr", 32'(write_ptr), 0);
    check("arst_level", 32'(write_level), 0);
    check("arst_full", 32'(full), 0);
    check("arst_afull", 32'(almost_full), 0);
    check("arst_ovf", 32'(overflow), 0);
    read_ptr_sync = '0;
    step();
    #2 write_reset = 1'b1;
    write_inc = 1'b1;
    #1;
    check("post_addr0", 32'(write_addr), 0);
    check("post_en", 32'(write_en), 1);
    step();
    check("post_addr1", 32'(write_addr), 1);
    check("post_level", 32'(write_level), 1);
    write_inc = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/write_ptr_full_ctrl.md
WRITE_PTR_FULL_CTRL -- requirements
Module: write_ptr_full_ctrl

Interface
REQ-001 Parameter: ADDR_SIZE, default 4, address width; FIFO depth = 2**ADDR_SIZE, legal range 2..12.
REQ-002 Parameter: AFULL_THRESH, default 2**ADDR_SIZE-2, level at or above which almost_full asserts; legal range 1..2**ADDR_SIZE.
REQ-003 write_clk  input  1  write-domain clock; all state on rising edge.
REQ-004 write_reset  input  1  asynchronous, active-low reset.
REQ-005 write_inc  input  1  write request for the current cycle.
REQ-006 read_ptr_sync  input  ADDR_SIZE+1  Gray-coded read pointer, already synchronised into write_clk.
REQ-007 ovf_clear  input  1  clears the sticky overflow flag.
REQ-008 write_addr  output  ADDR_SIZE  binary RAM write address.
REQ-009 write_ptr  output  ADDR_SIZE+1  registered Gray write pointer for the read-domain synchroniser.
REQ-010 write_en  output  1  RAM write strobe, = write_inc & ~full (combinational).
REQ-011 full  output  1  registered full flag.
REQ-012 almost_full  output  1  registered almost-full flag.
REQ-013 write_level  output  ADDR_SIZE+1  registered occupancy, 0..2**ADDR_SIZE.
REQ-014 overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-015 The binary pointer bin (ADDR_SIZE+1 bits) shall advance by 1 when write_en=1, wrapping modulo 2**(ADDR_SIZE+1).
REQ-016 next_bin = bin + write_en; next_gray = (next_bin>>1)^next_bin; both registered each cycle; write_addr = bin[ADDR_SIZE-1:0]; write_ptr = registered gray.
REQ-017 full shall be registered from next_gray: asserts when next_gray equals read_ptr_sync with the two MSBs inverted and all other bits equal, so full rises on the same edge as the write that fills the FIFO (zero-cycle lag).
REQ-018 The read pointer shall be Gray-to-binary converted (rbin); next_level = next_bin - rbin, modulo 2**(ADDR_SIZE+1), registered into write_level.
REQ-019 almost_full shall register (next_level >= AFULL_THRESH); with AFULL_THRESH = 2**ADDR_SIZE it equals full.
REQ-020 A write while full shall be dropped: no pointer, address or level change.
REQ-021 full and write_level shall deassert or fall only via read_ptr_sync movement, reflected one cycle after the synchronised value changes.
REQ-022 Write and read-pointer advance in the same cycle: level unchanged, full stays consistent with REQ-017.
REQ-023 Pointer wrap (bin 2**(ADDR_SIZE+1)-1 -> 0) shall not disturb level, full or almost_full.

Reset
REQ-024 On write_reset=0, asynchronously: bin=0, gray=0, full=0, almost_full=0, write_level=0, overflow=0; write_addr=0, write_ptr=0.
REQ-025 Reset mid-operation shall discard all state; the first write after release shall use write_addr=0.
REQ-026 Reset release is synchronous to write_clk; pointers update only on edges with write_reset=1.

Configuration
REQ-027 Macro WRITE_FULL_OVF_EN: when defined, overflow sets on any edge with write_inc=1 and full=1, holds until ovf_clear=1; set takes priority over clear in the same cycle.
REQ-028 When WRITE_FULL_OVF_EN is undefined, overflow shall be tied to 0, ovf_clear ignored, and no overflow register synthesised.

Structure
REQ-029 A shared package shall hold the default ADDR_SIZE, the depth function 2**ADDR_SIZE and the default AFULL_THRESH.
REQ-030 Gray-to-binary conversion shall be a separate parametrised sub-module gray2bin (width parameter), reusable by the read side.

Verification (ADDR_SIZE=4, AFULL_THRESH=14)
REQ-031 Reset, then 16 consecutive writes with read_ptr_sync=0 -> write_addr 0..15, almost_full rises after write 14, full=1 after write 16, write_level=16, write_ptr=5'b11000.
REQ-032 Full, write_inc=1 for 3 cycles -> pointers and level unchanged, write_en=0; overflow=1 if WRITE_FULL_OVF_EN, else 0; ovf_clear=1 -> overflow=0 next edge.
REQ-033 Full, read_ptr_sync steps to Gray of 1 (5'b00001) -> next edge full=0, write_level=15, almost_full=1.
REQ-034 Continuous writes and matching read pointer for 40 cycles -> bin wraps 31->0, write_level constant, no spurious full.
REQ-035 write_reset pulsed low mid-stream with level 9 -> all outputs 0 immediately, no clock needed; next write at write_addr=0.
REQ-036 Simultaneous write and read advance at level 15 -> level stays 15, full stays 0.
